// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC sequencer with an optional BHT/BTB branch predictor.
// Define BRANCH_PREDICT_EN to build the predictor; otherwise the PC runs sequentially.
module fetch_unit (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        stall,
  input  logic        fail_predict,
  input  logic [12:0] redir_pc,
  input  logic        upd_en,
  input  logic [12:0] upd_pc,
  input  logic        upd_taken,
  input  logic [12:0] upd_target,
  input  logic [1:0]  upd_state,
  input  logic [31:0] imem_data,
  output logic [12:0] imem_addr,
  output logic [12:0] pcF,
  output logic [31:0] instF,
  output logic [1:0]  stateF,
  output logic        hit_predict1
);

  logic [12:0] pc_q;
  logic [12:0] pc_d;

  assign pcF       = pc_q;
  assign imem_addr = pc_q;
  assign instF     = imem_data;

`ifdef BRANCH_PREDICT_EN

  logic [1:0]  bht     [64];
  logic        btb_v   [64];
  logic [4:0]  btb_tag [64];
  logic [12:0] btb_tgt [64];

  logic [5:0]  idx;
  logic [5:0]  upd_idx;
  logic        pred;
  logic        pred_q;
  logic [12:0] tgt_q;
  logic [1:0]  upd_cnt;
  logic        unused_ok;

  assign unused_ok    = ^upd_pc[1:0];
  assign idx          = pc_q[7:2];
  assign upd_idx      = upd_pc[7:2];
  assign stateF       = bht[idx];
  assign pred         = stateF[1] & btb_v[idx]
                      & (btb_tag[idx] == pc_q[12:8]);
  assign hit_predict1 = pred_q;

  // saturating step of the counter that travelled with the branch
  always_comb begin
    upd_cnt = upd_state;
    if (upd_taken) begin
      if (upd_state != 2'b11)
        upd_cnt = upd_state + 2'b01;
    end else if (upd_state != 2'b00) begin
      upd_cnt = upd_state - 2'b01;
    end
  end

  // one-shot prediction register: fires once, holds under stall
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      pred_q <= 1'b0;
      tgt_q  <= 13'h0;
    end else if (fail_predict) begin
      pred_q <= 1'b0;
    end else if (!stall) begin
      if (pred_q) begin
        pred_q <= 1'b0;
      end else begin
        pred_q <= pred;
        tgt_q  <= btb_tgt[idx];
      end
    end
  end

  // counters and valid bits, reset to weakly-not-taken / empty
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      for (int i = 0; i < 64; i++) begin
        bht[i]   <= 2'b01;
        btb_v[i] <= 1'b0;
      end
    end else if (upd_en) begin
      bht[upd_idx] <= upd_cnt;
      if (upd_taken)
        btb_v[upd_idx] <= 1'b1;
    end
  end

  // BTB payload needs no reset, it is qualified by btb_v
  always_ff @(posedge CLK) begin
    if (NRST && upd_en && upd_taken) begin
      btb_tag[upd_idx] <= upd_pc[12:8];
      btb_tgt[upd_idx] <= upd_target;
    end
  end

  // next fetch PC: redirect, hold, predicted target, sequential
  always_comb begin
    if (fail_predict)
      pc_d = redir_pc;
    else if (stall)
      pc_d = pc_q;
    else if (pred_q)
      pc_d = tgt_q;
    else
      pc_d = pc_q + 13'd4;
  end

`else

  logic unused_ok;

  assign unused_ok    = ^{upd_en, upd_pc, upd_taken,
                          upd_target, upd_state};
  assign stateF       = 2'b00;
  assign hit_predict1 = 1'b0;

  // next fetch PC: redirect, hold, sequential
  always_comb begin
    if (fail_predict)
      pc_d = redir_pc;
    else if (stall)
      pc_d = pc_q;
    else
      pc_d = pc_q + 13'd4;
  end

`endif

  // fetch PC register
  always_ff @(posedge CLK) begin
    if (!NRST)
      pc_q <= 13'h0;
    else
      pc_q <= pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a behavioural predictor model.
// Follows BRANCH_PREDICT_EN the same way the design does.
module tb_fetch_unit;

`ifdef BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        NRST;
  logic        stall;
  logic        fail_predict;
  logic [12:0] redir_pc;
  logic        upd_en;
  logic [12:0] upd_pc;
  logic        upd_taken;
  logic [12:0] upd_target;
  logic [1:0]  upd_state;
  logic [31:0] imem_data;
  logic [12:0] imem_addr;
  logic [12:0] pcF;
  logic [31:0] instF;
  logic [1:0]  stateF;
  logic        hit_predict1;

  fetch_unit dut (
    .CLK(CLK), .NRST(NRST), .stall(stall),
    .fail_predict(fail_predict), .redir_pc(redir_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_state(upd_state),
    .imem_data(imem_data), .imem_addr(imem_addr),
    .pcF(pcF), .instF(instF), .stateF(stateF),
    .hit_predict1(hit_predict1)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [12:0] a);
    return {a, ~a, 6'h2A};
  endfunction

  assign imem_data = mem(imem_addr);

  typedef struct {
    int          pc;
    int          st;
    bit          hit;
    logic [31:0] inst;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit m_known = 1'b0;
  int m_pc;
  bit m_pend;
  int m_tgt;
  int m_bht[64];
  bit m_v[64];
  int m_tag[64];
  int m_btgt[64];

  function automatic void chk(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endfunction

  task automatic step(input bit r, input bit s, input bit f,
                      input int rd, input bit ue, input int up,
                      input bit ut, input int utg, input int us);
    int i;
    int j;
    bit pr;
    int npc;
    if (!r) begin
      m_pc = 0; m_pend = 0; m_tgt = 0; m_known = 1;
      for (int k = 0; k < 64; k++) begin
        m_bht[k] = 1; m_v[k] = 0;
      end
      return;
    end
    if (!m_known) return;
    i  = (m_pc / 4) % 64;
    pr = PE && m_bht[i] >= 2 && m_v[i] && m_tag[i] == m_pc / 256;
    if (f)                npc = rd;
    else if (s)           npc = m_pc;
    else if (PE && m_pend) npc = m_tgt;
    else                  npc = (m_pc + 4) % 8192;
    if (f) m_pend = 0;
    else if (!s) begin
      if (m_pend) m_pend = 0;
      else begin
        m_pend = pr;
        m_tgt  = m_btgt[i];
      end
    end
    if (PE && ue) begin
      j = (up / 4) % 64;
      if (ut) m_bht[j] = (us >= 3) ? 3 : us + 1;
      else    m_bht[j] = (us <= 0) ? 0 : us - 1;
      if (ut) begin
        m_v[j] = 1; m_tag[j] = up / 256; m_btgt[j] = utg;
      end
    end
    m_pc = npc;
  endtask

  task automatic cyc(input bit r, input bit s, input bit f,
                     input int rd, input bit ue, input int up,
                     input bit ut, input int utg, input int us);
    exp_t e;
    NRST = r; stall = s; fail_predict = f;
    redir_pc = 13'(rd); upd_en = ue; upd_pc = 13'(up);
    upd_taken = ut; upd_target = 13'(utg); upd_state = 2'(us);
    if (m_known) begin
      e.pc   = m_pc;
      e.st   = PE ? m_bht[(m_pc / 4) % 64] : 0;
      e.hit  = PE ? m_pend : 1'b0;
      e.inst = mem(13'(m_pc));
      q.push_back(e);
    end
    step(r, s, f, rd, ue, up, ut, utg, us);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(); cyc(1,0,0,0,0,0,0,0,0); endtask
  task automatic rst();  cyc(0,0,0,0,0,0,0,0,0); endtask
  task automatic free(input int n);
    for (int k = 0; k < n; k++) idle();
  endtask
  task automatic train10();
    rst();
    cyc(1,0,0,0,1,'h010,1,'h100,1);
    free(3);
  endtask

  // monitor: compare every cycle's outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_pcF",   32'(pcF),          32'(e.pc));
        chk("sb_addr",  32'(imem_addr),    32'(e.pc));
        chk("sb_state", 32'(stateF),       32'(e.st));
        chk("sb_hit",   32'(hit_predict1), 32'(e.hit));
        chk("sb_inst",  instF,             e.inst);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int up;
    rst();
    chk("rst_pc",  32'(pcF), 32'h0);
    chk("rst_st",  32'(stateF), PE ? 32'd1 : 32'd0);
    chk("rst_hit", 32'(hit_predict1), 32'd0);
    for (int k = 1; k < 4; k++) begin
      idle();
      chk("seq_pc", 32'(pcF), 32'(4 * k));
    end

    train10();
    chk("tr_pc", 32'(pcF), 32'h010);
    chk("tr_st", 32'(stateF), PE ? 32'd2 : 32'd0);
    idle();
    chk("tk_pc",  32'(pcF), 32'h014);
    chk("tk_hit", 32'(hit_predict1), 32'(PE));
    idle();
    chk("tg_pc",  32'(pcF), PE ? 32'h100 : 32'h018);
    chk("tg_hit", 32'(hit_predict1), 32'd0);

    train10();
    idle();
    for (int k = 0; k < 3; k++) begin
      cyc(1,1,0,0,0,0,0,0,0);
      chk("stl_pc",  32'(pcF), 32'h014);
      chk("stl_hit", 32'(hit_predict1), 32'(PE));
    end
    idle();
    chk("stl_out", 32'(pcF), PE ? 32'h100 : 32'h018);

    train10();
    idle();
    cyc(1,0,1,'h040,0,0,0,0,0);
    chk("fp_pc",  32'(pcF), 32'h040);
    chk("fp_hit", 32'(hit_predict1), 32'd0);

    rst();
    cyc(1,0,1,'h1FFC,0,0,0,0,0);
    chk("wr_top", 32'(pcF), 32'h1FFC);
    idle();
    chk("wr_pc", 32'(pcF), 32'h0);

    rst();
    cyc(1,0,0,0,1,'h020,1,'h200,3);
    cyc(1,0,0,0,1,'h024,0,'h000,0);
    free(6);
    chk("sat_hi", 32'(pcF) << 2 | 32'(stateF),
        (32'h020 << 2) | (PE ? 32'd3 : 32'd0));
    idle();
    chk("sat_lo", 32'(pcF) << 2 | 32'(stateF), 32'h024 << 2);

    rst();
    for (int k = 0; k < 2000; k++) begin
      up = $urandom_range(0, 127) * 4;
      if ($urandom_range(0, 3) == 0)
        up = (up % 256) + 256 * $urandom_range(0, 31);
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 127) * 4,
          $urandom_range(0, 2) == 0,
          up,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 127) * 4,
          $urandom_range(0, 3));
    end
    idle();
    @(negedge CLK);
    #1;
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
